// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined N:1 mux family.
// Mode encoding, leaf-group size and the select-width function.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int unsigned GRP = 4;

    function automatic int unsigned sel_width(input int unsigned n_ch);
        return $clog2(n_ch);
    endfunction

endpackage

// File: rtl/mux_grp4.sv
// W-bit 4:1 leaf multiplexer, purely combinational.
// Channel j of the group is d[j*W +: W].
module mux_grp4
    import mux_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [GRP*W-1:0] d,
    input  logic [1:0]       s,
    output logic [W-1:0]     y
);

    always_comb begin
        y = d[0 +: W];
        unique case (s)
            2'd0: y = d[0*W +: W];
            2'd1: y = d[1*W +: W];
            2'd2: y = d[2*W +: W];
            2'd3: y = d[3*W +: W];
            default: y = d[0 +: W];
        endcase
    end

endmodule

// File: rtl/mux_pipe_nto1.sv
// Two-stage pipelined N_CH:1 mux with valid/ready output and round-robin auto-scan.
// Define MUX_PIPE_PARITY_EN to add a registered even-parity output out_par.
module mux_pipe_nto1
    import mux_pkg::*;
#(
    parameter int unsigned N_CH  = 16,
    parameter int unsigned W     = 8,
    localparam int unsigned SEL_W = sel_width(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] in_data,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic              sel_vld,
    output logic              in_rdy,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_vld,
`ifdef MUX_PIPE_PARITY_EN
    output logic              out_par,
`endif
    input  logic              out_rdy
);

    localparam int unsigned NGRP = N_CH / GRP;
    localparam int unsigned HI_W = SEL_W - 2;

    logic             mode_q;
    logic [SEL_W-1:0] scan_idx_q, scan_idx_d;
    logic             s1_vld_q;
    logic [W-1:0]     grp_q [NGRP];
    logic [W-1:0]     grp_d [NGRP];
    logic [HI_W-1:0]  hi_q;
    logic [SEL_W-1:0] ch_q;
    logic [W-1:0]     s2_word;

    logic             s1_load, s2_load;
    logic             scan_start, req;
    logic [SEL_W-1:0] idx;

    assign s2_load    = !out_vld || out_rdy;
    assign s1_load    = !s1_vld_q || s2_load;
    assign in_rdy     = s1_load;
    assign scan_start = (mode == MODE_SCAN) && (mode_q == MODE_DIRECT);

    // Entering scan mode forces the index to 0 in the same cycle it is used.
    always_comb begin
        idx        = sel;
        req        = sel_vld;
        scan_idx_d = scan_idx_q;
        if (mode == MODE_SCAN) begin
            idx        = scan_start ? '0 : scan_idx_q;
            req        = 1'b1;
            scan_idx_d = s1_load ? idx + 1'b1 : idx;
        end
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_leaf
        mux_grp4 #(
            .W (W)
        ) u_grp (
            .d (in_data[g*GRP*W +: GRP*W]),
            .s (idx[1:0]),
            .y (grp_d[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_DIRECT;
            scan_idx_q <= '0;
            s1_vld_q   <= 1'b0;
            hi_q       <= '0;
            ch_q       <= '0;
            for (int i = 0; i < NGRP; i++) grp_q[i] <= '0;
        end else begin
            mode_q     <= mode;
            scan_idx_q <= scan_idx_d;
            if (s1_load) begin
                s1_vld_q <= req;
                if (req) begin
                    grp_q <= grp_d;
                    hi_q  <= idx[SEL_W-1:2];
                    ch_q  <= idx;
                end
            end
        end
    end

    assign s2_word = grp_q[hi_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_ch   <= '0;
`ifdef MUX_PIPE_PARITY_EN
            out_par  <= 1'b0;
`endif
        end else if (s2_load) begin
            out_vld <= s1_vld_q;
            if (s1_vld_q) begin
                out_data <= s2_word;
                out_ch   <= ch_q;
`ifdef MUX_PIPE_PARITY_EN
                out_par  <= ^s2_word;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mux_pipe_nto1.sv
// Scoreboard bench for mux_pipe_nto1: accepted requests are queued from a channel-level model,
// and every presented output word is compared against the queue head.
module tb_mux_pipe_nto1;

    localparam int unsigned N_CH  = 16;
    localparam int unsigned W     = 8;
    localparam int unsigned SEL_W = 4;

    typedef struct packed {
        logic [SEL_W-1:0] ch;
        logic [W-1:0]     data;
    } word_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_CH*W-1:0] in_data;
    logic              mode;
    logic [SEL_W-1:0]  sel;
    logic              sel_vld;
    logic              in_rdy;
    logic [W-1:0]      out_data;
    logic [SEL_W-1:0]  out_ch;
    logic              out_vld;
    logic              out_rdy;
`ifdef MUX_PIPE_PARITY_EN
    logic              out_par;
`endif

    int    checks   = 0;
    int    failures = 0;
    word_t exp_q[$];
    logic  rand_data;
    int    next_scan;
    logic  prev_mode;

    mux_pipe_nto1 #(
        .N_CH (N_CH),
        .W    (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .mode     (mode),
        .sel      (sel),
        .sel_vld  (sel_vld),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_ch   (out_ch),
        .out_vld  (out_vld),
`ifdef MUX_PIPE_PARITY_EN
        .out_par  (out_par),
`endif
        .out_rdy  (out_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Request side of the model: a request is taken when in_rdy is high at the clock edge.
    always @(negedge clk) begin : push_blk
        int    ch;
        word_t w;
        #1;
        if (!rst_n) begin
            next_scan = 0;
            prev_mode = 1'b0;
        end else begin
            if (mode && !prev_mode) next_scan = 0;
            if (in_rdy && (mode || sel_vld)) begin
                ch     = mode ? next_scan : int'(sel);
                w.ch   = SEL_W'(ch);
                w.data = in_data[ch*W +: W];
                exp_q.push_back(w);
                if (mode) next_scan = (next_scan + 1) % N_CH;
            end
            prev_mode = mode;
        end
    end

    // Monitor: the queue holds exactly the words inside the two pipeline stages.
    always @(negedge clk) begin : pop_blk
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check("in_rdy", 32'(in_rdy), 32'(!(exp_q.size() == 2 && !out_rdy)));
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_vld", 32'(out_vld), 32'd0);
                end else begin
                    check("out_ch", 32'(out_ch), 32'(exp_q[0].ch));
                    check("out_data", 32'(out_data), 32'(exp_q[0].data));
`ifdef MUX_PIPE_PARITY_EN
                    check("out_par", 32'(out_par), 32'(^exp_q[0].data));
`endif
                    if (out_rdy) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_data)
            for (int k = 0; k < N_CH; k++) in_data[k*W +: W] = W'($urandom);
    endtask

    task automatic wait_first_out(input string name, input int exp_ch);
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_vld) begin
                seen = 1'b1;
                check(name, 32'(out_ch), 32'(exp_ch));
            end
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        sel_vld   = 1'b0;
        out_rdy   = 1'b0;
        rand_data = 1'b0;
        for (int k = 0; k < N_CH; k++) in_data[k*W +: W] = W'(8'hA0 + k);
        #12;
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_in_rdy", 32'(in_rdy), 32'd1);
        step();
        rst_n = 1'b1;

        // Direct select of channel 5: visible two edges after acceptance, for one cycle.
        step();
        sel = 4'd5; sel_vld = 1'b1; out_rdy = 1'b1;
        step();
        sel_vld = 1'b0;
        @(negedge clk);
        check("direct_lat_early", 32'(out_vld), 32'd0);
        step();
        @(negedge clk);
        check("direct_vld", 32'(out_vld), 32'd1);
        check("direct_data", 32'(out_data), 32'hA5);
        check("direct_ch", 32'(out_ch), 32'd5);
        step();
        @(negedge clk);
        check("direct_single", 32'(out_vld), 32'd0);

        // Back-pressure: two words buffer, the third waits, then three transfers in one cycle.
        step();
        out_rdy = 1'b0; sel = 4'd1; sel_vld = 1'b1;
        @(negedge clk);
        check("bp_accept1", 32'(in_rdy), 32'd1);
        step();
        sel = 4'd2;
        @(negedge clk);
        check("bp_accept2", 32'(in_rdy), 32'd1);
        step();
        sel = 4'd3;
        @(negedge clk);
        check("bp_full", 32'(in_rdy), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            check("bp_hold_rdy", 32'(in_rdy), 32'd0);
            check("bp_hold_ch", 32'(out_ch), 32'd1);
        end
        step();
        out_rdy = 1'b1;
        @(negedge clk);
        check("bp_release_rdy", 32'(in_rdy), 32'd1);
        check("bp_first", 32'(out_ch), 32'd1);
        step();
        sel_vld = 1'b0;
        @(negedge clk);
        check("bp_second", 32'(out_ch), 32'd2);
        step();
        @(negedge clk);
        check("bp_third", 32'(out_ch), 32'd3);
        step();
        step();

        // Scan: continuous channels from 0 two edges after mode rises, wrapping, up to 9.
        mode = 1'b1; rand_data = 1'b1;
        step();
        for (int i = 0; i < 26; i++) begin
            step();
            @(negedge clk);
            check("scan_vld", 32'(out_vld), 32'd1);
            check("scan_ch", 32'(out_ch), 32'(i % N_CH));
        end
        step();
        mode = 1'b0;
        step();
        step();
        step();
        mode = 1'b1;
        wait_first_out("scan_restart", 0);

        // Random traffic with mode toggles and back-pressure.
        for (int i = 0; i < 400; i++) begin
            step();
            if ($urandom_range(15) == 0) mode = ~mode;
            sel     = SEL_W'($urandom);
            sel_vld = 1'($urandom);
            out_rdy = ($urandom_range(9) < 7);
        end

        // Asynchronous reset with both stages full.
        step();
        mode = 1'b0; out_rdy = 1'b0; sel_vld = 1'b1;
        step();
        step();
        step();
        @(negedge clk);
        check("pre_rst_full", 32'(in_rdy), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_vld", 32'(out_vld), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_ch", 32'(out_ch), 32'd0);
        step();
        rst_n = 1'b1; mode = 1'b1; out_rdy = 1'b1; sel_vld = 1'b0;
        wait_first_out("rst_scan_restart", 0);
        for (int i = 0; i < 20; i++) begin
            step();
            out_rdy = ($urandom_range(3) != 0);
        end

`ifdef MUX_PIPE_PARITY_EN
        step();
        mode = 1'b0; out_rdy = 1'b1; sel_vld = 1'b0; rand_data = 1'b0;
        step();
        step();
        step();
        in_data[2*W +: W] = 8'hB3;
        in_data[3*W +: W] = 8'h03;
        sel = 4'd2; sel_vld = 1'b1;
        step();
        sel = 4'd3;
        step();
        sel_vld = 1'b0;
        @(negedge clk);
        check("par_b3", 32'(out_par), 32'd1);
        step();
        @(negedge clk);
        check("par_03", 32'(out_par), 32'd0);
`endif

        // Drain: everything accepted must have come out.
        step();
        mode = 1'b0; sel_vld = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        #2;
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_pipe_nto1.md
# mux_pipe_nto1

Parametrised, pipelined N-channel, W-bit-wide multiplexer. It is the next generation of the team's 16:1 bit mux tree and is built from the same 4:1 leaf-group structure. It adds a registered two-stage select path, a valid/ready output handshake with back-pressure, and an auto-scan mode that sweeps all channels round-robin. It sits between sampled input banks and a single downstream consumer, such as a serialiser or monitor port.

## Interface
Parameters:
- N_CH, 16: number of input channels; power of 2, range 8..64.
- W, 8: data width per channel; range 1..32.
- SEL_W, $clog2(N_CH): localparam, select/channel-index width.

Ports:
- Clock and reset (already decided): one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N_CH*W  packed channels; channel k is in_data[k*W +: W].
- mode  input  1  0 = direct select, 1 = auto-scan.
- sel  input  SEL_W  channel index, used in direct mode only.
- sel_vld  input  1  direct-mode request strobe; ignored in scan mode.
- in_rdy  output  1  request accepted this cycle (stage 1 can load).
- out_data  output  W  selected channel data.
- out_ch  output  SEL_W  index of the channel held in out_data.
- out_vld  output  1  out_data/out_ch valid.
- out_rdy  input  1  consumer accepts when out_vld & out_rdy.

## Operation
- Stage 1 (S1):
  - N_CH/4 leaf groups, each selecting one of 4 channels using sel[1:0].
  - Registers the N_CH/4 group results, the upper select bits, the full channel index and a valid bit s1_vld.
- Stage 2 (S2):
  - Selects among the registered group results using the upper select bits sel[SEL_W-1:2].
  - Registers the result into out_data and out_ch, and sets out_vld.
- Stall rules:
  - S2 loads when !out_vld | out_rdy.
  - S1 loads when !s1_vld | S2 loads.
  - in_rdy = S1 loads.
  - A stalled stage holds all its registers unchanged.
- Direct mode:
  - An S1 load with sel_vld=1 captures in_data sampled that cycle, indexed by sel.
  - An S1 load with sel_vld=0 writes s1_vld=0 (a bubble).
- Scan mode:
  - Internal counter scan_idx drives the index.
  - Every S1 load is a request; no sel_vld is needed.
  - scan_idx increments after each S1 load and wraps from N_CH-1 to 0.
- Mode change:
  - On the first cycle where mode is 1 after having been 0 (registered edge detect), scan_idx is forced to 0 before use.
  - Data already in flight in S1/S2 completes unaffected.
- Data is sampled once, at S1 load. Later changes to in_data do not affect in-flight words.

## Timing
- Reset values: out_data=0, out_ch=0, out_vld=0, s1_vld=0, scan_idx=0, mode edge register=0.
- in_rdy=1 after reset (combinational from the stall equations).
- Latency: request accepted on cycle t gives out_vld=1 at t+2, provided no stall.
- Throughput: 1 word per cycle while out_rdy=1.
- Back-pressure: with out_rdy=0 and out_vld=1, S2 holds.
  - S1 accepts at most one more word, then in_rdy=0.
  - Exactly 2 words are buffered; none are dropped or duplicated.
- Simultaneous: out_rdy=1 while both stages are full and a new request is present gives all three transfers in the same cycle.
- Reset mid-operation:
  - Asynchronous clear of all state listed under reset values.
  - In-flight words are discarded.
  - Scan restarts at channel 0.
- sel is a don't-care when sel_vld=0 or mode=1.

## Configuration
- Macro: MUX_PIPE_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit), even parity over out_data: ^out_data, registered in S2 alongside the data.
  - Reset value 0.
  - Held during stall.
- Undefined: port absent; no parity logic.

## Structure
- Shared package mux_pkg:
  - mode encoding constants: MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
  - group size constant GRP=4.
  - function computing SEL_W.
- Sub-module mux_grp4: W-bit 4:1 leaf mux, combinational, parametrised on W.
  - Instantiated N_CH/4 times in S1.
  - S2 reuses it recursively or uses an indexed select when N_CH/4 > 4.

## Test plan
- Reset then direct select: N_CH=16, W=8, in_data[k]=8'hA0+k, sel=5, sel_vld pulse at t → out_data=8'hA5, out_ch=5, out_vld=1 at t+2, single cycle.
- Back-pressure:
  - Stimulus: out_rdy=0, three back-to-back requests for channels 1, 2, 3.
  - Required: in_rdy drops after 2 accepts.
  - Required: on out_rdy=1, outputs are ch1 then ch2 on consecutive cycles.
  - Required: ch3 is accepted only after in_rdy returns, and no loss occurs.
- Scan wrap: mode=1, out_rdy=1 → out_ch sequence 0,1,…,15,0,1 starting 2 cycles after mode rises, with out_vld continuously 1.
- Mode toggle mid-scan:
  - Stimulus: scan running at index 9, then mode=0 for 3 cycles, then mode=1.
  - Required: the scan restarts at out_ch=0.
- Async reset mid-flight: assert rst_n=0 with both stages full → out_vld=0, out_data=0 immediately, without a clock edge.
- MUX_PIPE_PARITY_EN defined: selected word 8'hB3 → out_par=1; 8'h03 → out_par=0.
